// File: rtl/csa_operand_sequencer.sv
// Groups a valid/ready word stream into operand triples for the three-operand adder and
// registers the adder result behind a valid/ready output handshake.
module csa_operand_sequencer #(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned RES_W  = DATA_W + 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic [DATA_W-1:0] csa_a,
    output logic [DATA_W-1:0] csa_b,
    output logic [DATA_W-1:0] csa_c,
    input  logic [DATA_W:0]   csa_sum,
    input  logic              csa_carry,
    output logic [RES_W-1:0]  out_sum,
    output logic [1:0]        out_cnt,
    output logic              out_valid,
    input  logic              out_ready
);

    typedef enum logic [1:0] {StCollect, StEval, StOut} state_e;

    state_e              state_q, state_d;
    logic [1:0]          cnt_q, cnt_d;
    logic [1:0]          grp_cnt_q, grp_cnt_d;
    logic [DATA_W-1:0]   op_a_q, op_a_d;
    logic [DATA_W-1:0]   op_b_q, op_b_d;
    logic [DATA_W-1:0]   op_c_q, op_c_d;
    logic [RES_W-1:0]    out_sum_q, out_sum_d;
    logic [1:0]          out_cnt_q, out_cnt_d;
    logic                out_valid_q, out_valid_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StCollect;
            cnt_q       <= '0;
            grp_cnt_q   <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            op_c_q      <= '0;
            out_sum_q   <= '0;
            out_cnt_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            grp_cnt_q   <= grp_cnt_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            op_c_q      <= op_c_d;
            out_sum_q   <= out_sum_d;
            out_cnt_q   <= out_cnt_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        grp_cnt_d   = grp_cnt_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        op_c_d      = op_c_q;
        out_sum_d   = out_sum_q;
        out_cnt_d   = out_cnt_q;
        out_valid_d = out_valid_q;

        unique case (state_q)
            StCollect: begin
                if (in_valid) begin
                    case (cnt_q)
                        2'd0:    op_a_d = in_data;
                        2'd1:    op_b_d = in_data;
                        default: op_c_d = in_data;
                    endcase
                    cnt_d = cnt_q + 2'd1;
                    // Unfilled operands were cleared at group start, so in_last just closes early.
                    if (cnt_q == 2'd2 || in_last) begin
                        grp_cnt_d = cnt_q + 2'd1;
                        state_d   = StEval;
                    end
                end
            end
            StEval: begin
                out_sum_d   = {csa_carry, csa_sum};
                out_cnt_d   = grp_cnt_q;
                out_valid_d = 1'b1;
                state_d     = StOut;
            end
            StOut: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    op_a_d      = '0;
                    op_b_d      = '0;
                    op_c_d      = '0;
                    cnt_d       = '0;
                    state_d     = StCollect;
                end
            end
            default: state_d = StCollect;
        endcase
    end

    assign in_ready  = (state_q == StCollect);
    assign csa_a     = op_a_q;
    assign csa_b     = op_b_q;
    assign csa_c     = op_c_q;
    assign out_sum   = out_sum_q;
    assign out_cnt   = out_cnt_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_csa_operand_sequencer.sv
// Scoreboard bench for csa_operand_sequencer with a behavioural three-operand adder attached.
module tb_csa_operand_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       in_last = 1'b0;
    logic       in_ready;
    logic [3:0] csa_a, csa_b, csa_c;
    logic [4:0] csa_sum;
    logic       csa_carry;
    logic [5:0] out_sum;
    logic [1:0] out_cnt;
    logic       out_valid;
    logic       out_ready = 1'b1;

    int checks = 0;
    int errors = 0;
    logic [7:0] sb[$];  // {sum, cnt}

    always #5 clk = ~clk;

    assign {csa_carry, csa_sum} = 6'(csa_a) + 6'(csa_b) + 6'(csa_c);

    csa_operand_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .csa_a     (csa_a),
        .csa_b     (csa_b),
        .csa_c     (csa_c),
        .csa_sum   (csa_sum),
        .csa_carry (csa_carry),
        .out_sum   (out_sum),
        .out_cnt   (out_cnt),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: out_ready only changes just after posedge, so a handshake seen here completes.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_output", 1, 0);
            end else begin
                logic [7:0] e;
                e = sb.pop_front();
                chk("out_sum", int'(out_sum), int'(e[7:2]));
                chk("out_cnt", int'(out_cnt), int'(e[1:0]));
            end
        end
    end

    task automatic send(input logic [3:0] d, input logic last);
        int t;
        bit done;
        t = 0;
        done = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        while (!done) begin
            @(negedge clk);
            if (in_ready) done = 1;
            @(posedge clk);
            #1;
            t++;
            if (!done && t > 200) begin
                chk("send_timeout", 0, 1);
                done = 1;
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic expect_res(input int sum, input int cnt);
        sb.push_back({6'(sum), 2'(cnt)});
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 500) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("drain_empty", sb.size(), 0);
    endtask

    bit stall_on = 0;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #3;
        chk("rst_csa_a", int'(csa_a), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_sum", int'(out_sum), 0);
        chk("rst_out_cnt", int'(out_cnt), 0);
        #20 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in_ready", int'(in_ready), 1);

        // 1: 3,5,7 with timing of EVAL/OUT
        expect_res(15, 3);
        send(4'd3, 1'b0);
        send(4'd5, 1'b0);
        send(4'd7, 1'b0);
        chk("t1_csa_a", int'(csa_a), 3);
        chk("t1_csa_b", int'(csa_b), 5);
        chk("t1_csa_c", int'(csa_c), 7);
        chk("t1_eval_valid", int'(out_valid), 0);
        chk("t1_eval_ready", int'(in_ready), 0);
        @(posedge clk);
        #1;
        chk("t1_out_valid", int'(out_valid), 1);
        chk("t1_out_ready_low", int'(in_ready), 0);
        @(posedge clk);
        #1;
        chk("t1_back_ready", int'(in_ready), 1);
        chk("t1_valid_drop", int'(out_valid), 0);
        chk("t1_csa_clear", int'(csa_a), 0);

        // 2: maximum sum
        expect_res(45, 3);
        send(4'd15, 1'b0);
        send(4'd15, 1'b0);
        send(4'd15, 1'b0);

        // 3: short groups
        expect_res(9, 1);
        send(4'd9, 1'b1);
        chk("t3_csa_a", int'(csa_a), 9);
        chk("t3_csa_b", int'(csa_b), 0);
        chk("t3_csa_c", int'(csa_c), 0);
        expect_res(10, 2);
        send(4'd4, 1'b0);
        send(4'd6, 1'b1);
        chk("t3b_csa_c", int'(csa_c), 0);
        drain();

        // 4: backpressure with a held offer of 8
        out_ready = 1'b0;
        expect_res(6, 3);
        send(4'd1, 1'b0);
        send(4'd2, 1'b0);
        send(4'd3, 1'b0);
        in_valid = 1'b1;
        in_data  = 4'd8;
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t4_hold_valid", int'(out_valid), 1);
            chk("t4_hold_sum", int'(out_sum), 6);
            chk("t4_in_ready", int'(in_ready), 0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        expect_res(10, 3);
        send(4'd8, 1'b0);
        chk("t4_first_word", int'(csa_a), 8);
        send(4'd1, 1'b0);
        send(4'd1, 1'b0);
        drain();

        // 5: asynchronous reset mid-group
        send(4'd7, 1'b0);
        send(4'd7, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_csa_a", int'(csa_a), 0);
        chk("t5_csa_b", int'(csa_b), 0);
        chk("t5_out_valid", int'(out_valid), 0);
        chk("t5_out_cnt", int'(out_cnt), 0);
        #10;
        rst_n = 1'b1;
        expect_res(3, 3);
        send(4'd1, 1'b0);
        send(4'd1, 1'b0);
        send(4'd1, 1'b0);
        drain();

        // 6: random back-to-back groups with stalls
        stall_on = 1;
        fork
            begin
                while (stall_on) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
            begin
                for (int g = 0; g < 10; g++) begin
                    int n;
                    int ref_sum;
                    n = $urandom_range(1, 3);
                    ref_sum = 0;
                    for (int w = 0; w < n; w++) begin
                        logic [3:0] v;
                        v = 4'($urandom_range(0, 15));
                        ref_sum += int'(v);
                        if (w == n - 1) expect_res(ref_sum, n);
                        send(v, (w == n - 1) && (n < 3));
                        repeat ($urandom_range(0, 2)) begin
                            @(posedge clk);
                            #1;
                        end
                    end
                end
                drain();
                stall_on = 0;
            end
        join
        out_ready = 1'b1;
        repeat (3) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
